// File: rtl/scc_run_controller.sv
// rtl/scc_run_controller.sv - SCC run controller: core reset sequencing, cycle budget, halt detect, write signature
module scc_run_controller #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 32,
    parameter int                CYC_W        = 16,
    parameter int                RESET_CYCLES = 2,
    parameter int                MAX_CYCLES   = 1000,
    parameter int                HALT_REPEAT  = 4,
    parameter logic [DATA_W-1:0] EXPECTED_SIG = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_mem_en,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_out,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CYC_W-1:0]  cycle_count,
    output logic [CYC_W-1:0]  write_count,
    output logic [DATA_W-1:0] signature
);

    localparam int RST_W  = $clog2(RESET_CYCLES + 1);
    localparam int HALT_W = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RESET_CORE = 2'd1,
        S_RUN        = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [RST_W-1:0]    rst_cnt, rst_cnt_n;
    logic [HALT_W-1:0]   halt_cnt, halt_cnt_n;
    logic [ADDR_W-1:0]   last_addr, last_addr_n;
    logic [CYC_W-1:0]    cycle_count_n, write_count_n;
    logic [DATA_W-1:0]   signature_n;
    logic                pass_n, timeout_n;
    logic                core_reset_n, busy_n, done_n;

    logic [DATA_W-1:0]   sig_fold;
    logic [DATA_W-1:0]   sig_run;
    logic [HALT_W-1:0]   halt_upd;
    logic                halt_hit;
    logic                budget_hit;

    // Signature of this cycle including a same-cycle write, so a halt on a write cycle compares the final value.
    assign sig_fold   = {signature[DATA_W-2:0], signature[DATA_W-1]} ^ data_out ^ DATA_W'(data_addr);
    assign sig_run    = data_write ? sig_fold : signature;
    assign halt_upd   = (in_mem_addr == last_addr) ? halt_cnt + HALT_W'(1) : HALT_W'(1);
    assign halt_hit   = in_mem_en && (halt_upd == HALT_W'(HALT_REPEAT));
    assign budget_hit = (cycle_count == CYC_W'(MAX_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            halt_cnt    <= '0;
            last_addr   <= '0;
            cycle_count <= '0;
            write_count <= '0;
            signature   <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            core_reset  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            rst_cnt     <= rst_cnt_n;
            halt_cnt    <= halt_cnt_n;
            last_addr   <= last_addr_n;
            cycle_count <= cycle_count_n;
            write_count <= write_count_n;
            signature   <= signature_n;
            pass        <= pass_n;
            timeout     <= timeout_n;
            core_reset  <= core_reset_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

    always_comb begin
        state_n       = state;
        rst_cnt_n     = rst_cnt;
        halt_cnt_n    = halt_cnt;
        last_addr_n   = last_addr;
        cycle_count_n = cycle_count;
        write_count_n = write_count;
        signature_n   = signature;
        pass_n        = pass;
        timeout_n     = timeout;

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n       = S_RESET_CORE;
                    rst_cnt_n     = '0;
                    halt_cnt_n    = '0;
                    last_addr_n   = '0;
                    cycle_count_n = '0;
                    write_count_n = '0;
                    signature_n   = '0;
                    pass_n        = 1'b0;
                    timeout_n     = 1'b0;
                end
            end
            S_RESET_CORE: begin
                if (rst_cnt == RST_W'(RESET_CYCLES - 1)) begin
                    state_n = S_RUN;
                end else begin
                    rst_cnt_n = rst_cnt + RST_W'(1);
                end
            end
            S_RUN: begin
                cycle_count_n = cycle_count + CYC_W'(1);
                signature_n   = sig_run;
                if (data_write && (write_count != '1)) begin
                    write_count_n = write_count + CYC_W'(1);
                end
                if (in_mem_en) begin
                    halt_cnt_n  = halt_upd;
                    last_addr_n = in_mem_addr;
                end
                // Halt is checked first so a halt on the last budget cycle is not reported as a timeout.
                if (halt_hit) begin
                    state_n   = S_DONE;
                    pass_n    = (sig_run == EXPECTED_SIG);
                    timeout_n = 1'b0;
                end else if (budget_hit) begin
                    state_n   = S_DONE;
                    pass_n    = 1'b0;
                    timeout_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        core_reset_n = (state_n != S_RUN);
        busy_n       = (state_n == S_RESET_CORE) || (state_n == S_RUN);
        done_n       = (state_n == S_DONE);
    end

endmodule

// File: tb/tb_scc_run_controller.sv
// tb/tb_scc_run_controller.sv - directed scoreboard bench for scc_run_controller
module tb_scc_run_controller;

    localparam int          ADDR_W       = 16;
    localparam int          DATA_W       = 32;
    localparam int          CYC_W        = 16;
    localparam int          RESET_CYCLES = 2;
    localparam int          MAX_CYCLES   = 20;
    localparam int          HALT_REPEAT  = 4;
    localparam logic [31:0] EXP_SIG      = 32'h0000_0021;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_mem_en;
    logic [ADDR_W-1:0] in_mem_addr;
    logic              data_write;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_out;
    logic              core_reset;
    logic              busy;
    logic              done;
    logic              pass;
    logic              timeout;
    logic [CYC_W-1:0]  cycle_count;
    logic [CYC_W-1:0]  write_count;
    logic [DATA_W-1:0] signature;

    always #5 clk = ~clk;

    scc_run_controller #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .CYC_W        (CYC_W),
        .RESET_CYCLES (RESET_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .HALT_REPEAT  (HALT_REPEAT),
        .EXPECTED_SIG (EXP_SIG)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_mem_en   (in_mem_en),
        .in_mem_addr (in_mem_addr),
        .data_write  (data_write),
        .data_addr   (data_addr),
        .data_out    (data_out),
        .core_reset  (core_reset),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .write_count (write_count),
        .signature   (signature)
    );

    typedef struct {
        logic        pass;
        logic        timeout;
        logic [15:0] cc;
        logic [15:0] wc;
        logic [31:0] sig;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_sig;
    logic [15:0] m_cc;
    logic [15:0] m_wc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, 64'(core_reset), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_pass"}, 64'(pass), 64'(0));
        check({tag, "_timeout"}, 64'(timeout), 64'(0));
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'(0));
        check({tag, "_write_count"}, 64'(write_count), 64'(0));
        check({tag, "_signature"}, 64'(signature), 64'(0));
    endtask

    task automatic run_cycle(input logic en, input logic [15:0] faddr, input logic wr,
                             input logic [15:0] waddr, input logic [31:0] wdata);
        in_mem_en   = en;
        in_mem_addr = faddr;
        data_write  = wr;
        data_addr   = waddr;
        data_out    = wdata;
        m_cc++;
        if (wr) begin
            m_wc++;
            m_sig = {m_sig[30:0], m_sig[31]} ^ wdata ^ {16'h0000, waddr};
        end
        tick();
        in_mem_en  = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic begin_run(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_restart_done"}, 64'(done), 64'(0));
        check({tag, "_restart_sig"}, 64'(signature), 64'(0));
        repeat (RESET_CYCLES) tick();
        check({tag, "_core_reset_low"}, 64'(core_reset), 64'(0));
        m_sig = '0;
        m_cc  = '0;
        m_wc  = '0;
    endtask

    task automatic push_exp(input logic p, input logic t);
        exp_t e;
        e.pass    = p;
        e.timeout = t;
        e.cc      = m_cc;
        e.wc      = m_wc;
        e.sig     = m_sig;
        sb.push_back(e);
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        int   waited = 0;
        while (!done && waited < 40) begin
            tick();
            waited++;
        end
        check({tag, "_done"}, 64'(done), 64'(1));
        check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_pass"}, 64'(pass), 64'(e.pass));
            check({tag, "_timeout"}, 64'(timeout), 64'(e.timeout));
            check({tag, "_cycle_count"}, 64'(cycle_count), 64'(e.cc));
            check({tag, "_write_count"}, 64'(write_count), 64'(e.wc));
            check({tag, "_signature"}, 64'(signature), 64'(e.sig));
        end
        check({tag, "_busy_low"}, 64'(busy), 64'(0));
        check({tag, "_core_reset_high"}, 64'(core_reset), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] fa;
        reset       = 1'b1;
        start       = 1'b0;
        in_mem_en   = 1'b0;
        in_mem_addr = '0;
        data_write  = 1'b0;
        data_addr   = '0;
        data_out    = '0;
        m_sig = '0;
        m_cc  = '0;
        m_wc  = '0;
        tick();
        tick();
        check_reset_values("por");
        reset = 1'b0;
        tick();
        check("idle_core_reset", 64'(core_reset), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));

        // Run A: reset timing, two writes, halt on 0x0020, matching signature.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a_busy_rise", 64'(busy), 64'(1));
        check("a_core_reset_c0", 64'(core_reset), 64'(1));
        tick();
        check("a_core_reset_c1", 64'(core_reset), 64'(1));
        tick();
        check("a_core_reset_fall", 64'(core_reset), 64'(0));
        check("a_busy_run", 64'(busy), 64'(1));
        check("a_cc0", 64'(cycle_count), 64'(0));
        run_cycle(1'b0, 16'h0000, 1'b1, 16'h0004, 32'h0000_0010);
        check("a_cc1", 64'(cycle_count), 64'(1));
        run_cycle(1'b0, 16'h0000, 1'b1, 16'h0008, 32'h0000_0001);
        check("a_cc2", 64'(cycle_count), 64'(2));
        repeat (3) run_cycle(1'b1, 16'h0020, 1'b0, 16'h0000, 32'h0);
        check("a_cc5", 64'(cycle_count), 64'(5));
        check("a_not_done_yet", 64'(done), 64'(0));
        run_cycle(1'b1, 16'h0020, 1'b0, 16'h0000, 32'h0);
        push_exp(1'b1, 1'b0);
        check_done("a");
        repeat (2) tick();
        check("a_frozen_cc", 64'(cycle_count), 64'(6));
        check("a_held_done", 64'(done), 64'(1));

        // Run B: restart from DONE, mismatching signature, start during RUN ignored.
        begin_run("b");
        run_cycle(1'b0, 16'h0000, 1'b1, 16'h0004, 32'h0000_0010);
        start = 1'b1;
        run_cycle(1'b1, 16'h0030, 1'b0, 16'h0000, 32'h0);
        start = 1'b0;
        check("b_start_ignored_busy", 64'(busy), 64'(1));
        check("b_start_ignored_cc", 64'(cycle_count), 64'(2));
        repeat (3) run_cycle(1'b1, 16'h0030, 1'b0, 16'h0000, 32'h0);
        push_exp(1'b0, 1'b0);
        check_done("b");

        // Run C: ever-incrementing fetch addresses exhaust the budget.
        begin_run("c");
        for (int i = 0; i < MAX_CYCLES - 1; i++) begin
            fa = 16'h0100 + 16'(i);
            run_cycle(1'b1, fa, (i == 5), 16'h0040, 32'hdead_beef);
        end
        check("c_not_done_early", 64'(done), 64'(0));
        run_cycle(1'b1, 16'h0200, 1'b0, 16'h0000, 32'h0);
        push_exp(1'b0, 1'b1);
        check_done("c");

        // Run D: halt lands on the final budget cycle with a write in that same cycle.
        begin_run("d");
        for (int i = 1; i <= MAX_CYCLES; i++) begin
            fa = (i >= MAX_CYCLES - HALT_REPEAT + 1) ? 16'h0300 : 16'h0200 + 16'(i);
            if (i == 1)
                run_cycle(1'b1, fa, 1'b1, 16'h0004, 32'h0000_0010);
            else if (i == MAX_CYCLES)
                run_cycle(1'b1, fa, 1'b1, 16'h0008, 32'h0000_0001);
            else
                run_cycle(1'b1, fa, 1'b0, 16'h0000, 32'h0);
        end
        push_exp(1'b1, 1'b0);
        check_done("d");

        // Run E: reset asserted mid-RUN.
        begin_run("e");
        repeat (3) run_cycle(1'b1, 16'h0050, 1'b1, 16'h0010, 32'h0000_0003);
        reset = 1'b1;
        tick();
        check_reset_values("midrun");
        reset = 1'b0;
        tick();
        check("e_idle_busy", 64'(busy), 64'(0));
        check("e_idle_done", 64'(done), 64'(0));
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
